// File: rtl/booth_r4_seq_mul_pkg.sv
// booth_pkg: shared types and helpers for the radix-4 Booth sequential multiplier.
//   state_t     : controller states IDLE / RUN / DONE
//   booth_sel_t : encoder selects {s (single), d (double), n (negate)}
//   n_iter()    : iteration count N for a given operand width
//   booth_enc() : triplet -> selects
// Optional feature macro: BOOTH_UNSIGNED_MODE_EN adds one iteration so that
// zero-extended (unsigned) operands can be handled.
package booth_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   typedef struct packed {
      logic s;
      logic d;
      logic n;
   } booth_sel_t;

`ifdef BOOTH_UNSIGNED_MODE_EN
   // Fixed latency in both modes; the extra triplet covers the unsigned MSB.
   localparam int EXTRA_ITER = 1;
`else
   localparam int EXTRA_ITER = 0;
`endif

   function automatic int n_iter(input int width);
      return width / 2 + EXTRA_ITER;
   endfunction

   function automatic booth_sel_t booth_enc(input logic [2:0] t);
      booth_sel_t sel;
      sel.s = t[1] ^ t[0];
      sel.d = (~t[2] & t[1] & t[0]) | (t[2] & ~t[1] & ~t[0]);
      sel.n = t[2];
      return sel;
   endfunction

endpackage

// File: rtl/booth_r4_seq_mul_if.sv
// booth_r4_seq_mul_if: operand/product handshake bundle for the multiplier.
//   in_valid/in_ready/a/b          : operand pair handshake
//   out_valid/out_ready/product    : product handshake
//   busy                           : multiplier is iterating
//   sgn (BOOTH_UNSIGNED_MODE_EN)   : 1 = signed operands, 0 = unsigned
// Modports: master = issue/writeback side, slave = multiplier.
interface booth_r4_seq_mul_if #(
   parameter int WIDTH = 16
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] product;
   logic               busy;
`ifdef BOOTH_UNSIGNED_MODE_EN
   logic               sgn;
`endif

   modport master (
      output in_valid, a, b, out_ready,
`ifdef BOOTH_UNSIGNED_MODE_EN
      output sgn,
`endif
      input  in_ready, out_valid, product, busy
   );

   modport slave (
      input  in_valid, a, b, out_ready,
`ifdef BOOTH_UNSIGNED_MODE_EN
      input  sgn,
`endif
      output in_ready, out_valid, product, busy
   );
endinterface

// File: rtl/booth_r4_seq_mul_pp_gen.sv
// booth_pp_gen: combinational radix-4 Booth partial-product slice.
//   triplet      : {b[2i+1], b[2i], b[2i-1]}
//   multiplicand : already extended by the caller (sign or zero), WIDTH bits
//   pp           : unshifted partial product, PP_W bits, two's complement
// Triplet 111 gives mag=0 with negate; ~0+1 wraps to 0, so no special case.
module booth_pp_gen
   import booth_pkg::*;
#(
   parameter int WIDTH = 17,
   parameter int PP_W  = 32
) (
   input  logic [2:0]       triplet,
   input  logic [WIDTH-1:0] multiplicand,
   output logic [PP_W-1:0]  pp
);
   booth_sel_t      sel;
   logic [PP_W-1:0] sext;
   logic [PP_W-1:0] mag;

   always_comb begin
      sel  = booth_enc(triplet);
      sext = {{(PP_W-WIDTH){multiplicand[WIDTH-1]}}, multiplicand};
      mag  = sel.s ? sext : (sel.d ? (sext << 1) : '0);
      pp   = (sel.n ? ~mag : mag) + PP_W'(sel.n);
   end
endmodule

// File: rtl/booth_r4_seq_mul.sv
// booth_r4_seq_mul: sequential radix-4 Booth multiplier, one triplet per clock.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : booth_r4_seq_mul_if.slave (operand / product handshakes, busy)
// Accept edge latches operands; N following edges each add one shifted partial
// product; the product register is loaded on the last iteration and held until
// the next DONE. In DONE, in_ready follows out_ready so a new pair can be taken
// on the same edge the product is consumed.
// Optional feature macro: BOOTH_UNSIGNED_MODE_EN (adds bus.sgn, N = WIDTH/2+1).
module booth_r4_seq_mul
   import booth_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH/2+1)
) (
   input  logic              clk,
   input  logic              rst_n,
   booth_r4_seq_mul_if.slave bus
);
   localparam int N    = n_iter(WIDTH);
   localparam int PW   = 2 * WIDTH;
   localparam int MW   = WIDTH + 1;   // multiplicand plus extension bit
   localparam int BW   = WIDTH + 2;   // extension bit, b, appended zero LSB

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [PW-1:0]    acc, acc_nxt, pp, product_q;
   logic [MW-1:0]    mcand;
   logic [BW-1:0]    mplier;
   logic             in_ready, out_valid, busy;
   logic             accept, last;
   logic             ext_a, ext_b;

`ifdef BOOTH_UNSIGNED_MODE_EN
   assign ext_a = bus.sgn & bus.a[WIDTH-1];
   assign ext_b = bus.sgn & bus.b[WIDTH-1];
`else
   assign ext_a = bus.a[WIDTH-1];
   assign ext_b = bus.b[WIDTH-1];
`endif

   assign accept = bus.in_valid & in_ready;
   assign last   = (cnt == CNT_W'(N-1));

   booth_pp_gen #(.WIDTH(MW), .PP_W(PW)) u_pp_gen (
      .triplet      (mplier[2:0]),
      .multiplicand (mcand),
      .pp           (pp)
   );

   assign acc_nxt = acc + (pp << {cnt, 1'b0});

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // next state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = RUN;
         RUN:  if (last)   state_nxt = DONE;
         DONE: if (bus.out_ready) state_nxt = accept ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // outputs
   always_comb begin
      in_ready  = 1'b0;
      busy      = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: in_ready = 1'b1;
         RUN:  busy     = 1'b1;
         DONE: begin
            out_valid = 1'b1;
            in_ready  = bus.out_ready;
         end
         default: ;
      endcase
   end

   // datapath: multiplier shifts right two bits per iteration, replicating its
   // top bit so the extra (unsigned-mode) triplet sees {0,0,b[W-1]} or {s,s,s}.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt       <= '0;
         acc       <= '0;
         product_q <= '0;
         mcand     <= '0;
         mplier    <= '0;
      end else if (accept) begin
         cnt    <= '0;
         acc    <= '0;
         mcand  <= {ext_a, bus.a};
         mplier <= {ext_b, bus.b, 1'b0};
      end else if (state == RUN) begin
         cnt    <= cnt + CNT_W'(1);
         acc    <= acc_nxt;
         mplier <= {{2{mplier[BW-1]}}, mplier[BW-1:2]};
         if (last) product_q <= acc_nxt;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.busy      = busy;
   assign bus.product   = product_q;
endmodule

// File: tb/tb_booth_r4_seq_mul.sv
// tb_booth_r4_seq_mul: randomized and directed bench for booth_r4_seq_mul
// (WIDTH=8), reference products from plain integer multiplication.
module tb_booth_r4_seq_mul;
   localparam int W  = 8;
   localparam int PW = 2 * W;
`ifdef BOOTH_UNSIGNED_MODE_EN
   localparam int N = W/2 + 1;
`else
   localparam int N = W/2;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sgn_mode = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   booth_r4_seq_mul_if #(.WIDTH(W)) bus();

`ifdef BOOTH_UNSIGNED_MODE_EN
   assign bus.sgn = sgn_mode;
`endif

   booth_r4_seq_mul #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic sgn);
      longint ix, iy;
      if (sgn) begin
         ix = longint'($signed(x));
         iy = longint'($signed(y));
      end else begin
         ix = longint'(x);
         iy = longint'(y);
      end
      return PW'(ix * iy);
   endfunction

   task automatic start(input logic [W-1:0] x, input logic [W-1:0] y);
      bus.a = x;
      bus.b = y;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.a = W'($urandom);
      bus.b = W'($urandom);
   endtask

   task automatic wait_out(output int cycles);
      cycles = 0;
      while (bus.out_valid !== 1'b1 && cycles < 50) begin
         tick();
         cycles++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
      vectors++; if (bus.product !== '0) begin miscompares++; $display("FAIL reset_product got %h want 0", bus.product); end
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [W-1:0]  av [4] = '{8'd7, 8'd5, 8'h80, 8'h7F};
      logic [W-1:0]  bv [4] = '{8'd3, 8'hFF, 8'h80, 8'h80};
      logic [PW-1:0] ev [4] = '{16'd21, 16'hFFFB, 16'h4000, 16'hC080};
      int cyc;
      sgn_mode = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         start(av[i], bv[i]);
         vectors++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL directed_run_flags[%0d] busy=%b in_ready=%b want 1/0", i, bus.busy, bus.in_ready); end
         wait_out(cyc);
         vectors++; if (cyc != N) begin miscompares++; $display("FAIL directed_latency[%0d] got %0d want %0d", i, cyc, N); end
         vectors++; if (bus.product !== ev[i]) begin miscompares++; $display("FAIL directed_product[%0d] got %h want %h", i, bus.product, ev[i]); end
         tick();
         vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL directed_one_cycle[%0d] out_valid=%b want 0", i, bus.out_valid); end
      end
   endtask

   task automatic test_random();
      logic [W-1:0]  x, y;
      logic [PW-1:0] e;
      int cyc;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         x = W'($urandom);
         y = W'($urandom);
`ifdef BOOTH_UNSIGNED_MODE_EN
         sgn_mode = 1'($urandom);
`endif
         e = ref_mul(x, y, sgn_mode);
         start(x, y);
         wait_out(cyc);
         vectors++; if (cyc != N || bus.product !== e) begin miscompares++; $display("FAIL random[%0d] a=%h b=%h sgn=%b got %h after %0d want %h after %0d", i, x, y, sgn_mode, bus.product, cyc, e, N); end
         tick();
      end
      sgn_mode = 1'b1;
   endtask

   task automatic test_backpressure();
      logic [PW-1:0] e;
      int cyc;
      e = ref_mul(8'hB3, 8'h2D, 1'b1);
      bus.out_ready = 1'b0;
      start(8'hB3, 8'h2D);
      // offer a different pair mid-RUN; it must be ignored
      bus.a = 8'h11;
      bus.b = 8'h22;
      bus.in_valid = 1'b1;
      tick();
      vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_run_in_ready got %b want 0", bus.in_ready); end
      bus.in_valid = 1'b0;
      wait_out(cyc);
      vectors++; if (cyc != N - 1) begin miscompares++; $display("FAIL bp_latency got %0d want %0d", cyc + 1, N); end
      for (int i = 0; i < 10; i++) begin
         tick();
         vectors++; if (bus.out_valid !== 1'b1 || bus.product !== e || bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_hold[%0d] valid=%b product=%h in_ready=%b want 1/%h/0", i, bus.out_valid, bus.product, bus.in_ready, e); end
      end
      bus.out_ready = 1'b1;
      tick();
      vectors++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready); end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0]  av [3] = '{8'd3, 8'hFE, 8'd0};
      logic [W-1:0]  bv [3] = '{8'd4, 8'd6, 8'hFB};
      logic [PW-1:0] ev [3] = '{16'd12, 16'hFFF4, 16'd0};
      int cyc;
      bus.out_ready = 1'b1;
      bus.a = av[0];
      bus.b = bv[0];
      bus.in_valid = 1'b1;
      tick();
      for (int k = 0; k < 3; k++) begin
         if (k < 2) begin
            bus.a = av[k+1];
            bus.b = bv[k+1];
         end else begin
            bus.in_valid = 1'b0;
         end
         wait_out(cyc);
         vectors++; if (cyc != N || bus.product !== ev[k]) begin miscompares++; $display("FAIL b2b[%0d] got %h after %0d want %h after %0d", k, bus.product, cyc, ev[k], N); end
         tick();
      end
      vectors++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL b2b_drain valid=%b busy=%b want 0/0", bus.out_valid, bus.busy); end
   endtask

   task automatic test_reset_mid();
      int cyc;
      bus.out_ready = 1'b1;
      start(8'd9, 8'd13);
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      vectors++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.product !== '0) begin miscompares++; $display("FAIL reset_mid valid=%b busy=%b in_ready=%b product=%h want 0/0/1/0", bus.out_valid, bus.busy, bus.in_ready, bus.product); end
      start(8'd2, 8'd2);
      wait_out(cyc);
      vectors++; if (cyc != N || bus.product !== 16'd4) begin miscompares++; $display("FAIL reset_mid_after got %h after %0d want 0004 after %0d", bus.product, cyc, N); end
      tick();
   endtask

`ifdef BOOTH_UNSIGNED_MODE_EN
   task automatic test_unsigned();
      int cyc;
      bus.out_ready = 1'b1;
      sgn_mode = 1'b0;
      start(8'hFF, 8'hFF);
      wait_out(cyc);
      vectors++; if (cyc != 5 || bus.product !== 16'hFE01) begin miscompares++; $display("FAIL unsigned_ff got %h after %0d want fe01 after 5", bus.product, cyc); end
      tick();
      sgn_mode = 1'b1;
      start(8'hFF, 8'hFF);
      wait_out(cyc);
      vectors++; if (cyc != 5 || bus.product !== 16'h0001) begin miscompares++; $display("FAIL signed_ff got %h after %0d want 0001 after 5", bus.product, cyc); end
      tick();
   endtask
`endif

   initial begin
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b1;
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
`ifdef BOOTH_UNSIGNED_MODE_EN
      test_unsigned();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/booth_r4_seq_mul.md
Name: booth_r4_seq_mul

Overview:
- Sequential radix-4 Booth multiplier controller for two's-complement operands.
- Iterates one Booth triplet per clock through a single encoder/partial-product slice, then accumulates the shifted partial product into a 2*WIDTH register.
- Takes operand pairs in, and hands products out, over valid/ready handshakes.
- Sits between the ALU issue logic and the writeback mux as the shared multiply resource.

Parameters:
- WIDTH, 16, operand width in bits; must be even and at least 4.
- CNT_W, $clog2(WIDTH/2+1), iteration counter width; derived, do not override.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair this cycle.
- a  in  WIDTH  multiplicand, two's complement.
- b  in  WIDTH  multiplier, two's complement.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts the product.
- product  out  2*WIDTH  signed product a*b.
- busy  out  1  high in RUN.

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-low (rst_n). Both are fixed.
- Reset, sampled on a clk edge with rst_n=0:
  - state=IDLE, counter=0, accumulator=0, product=0.
  - out_valid=0, busy=0; in_ready=1 in the cycle after reset.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - in_valid=1 latches a, b with an appended zero LSB, clears the accumulator and counter, and moves to RUN.
- RUN (N=WIDTH/2 iterations):
  - in_ready=0, busy=1.
  - Iteration i selects triplet {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0.
  - The encoder produces single s = b[2i] XOR b[2i-1], double d = (~b[2i+1] & b[2i] & b[2i-1]) | (b[2i+1] & ~b[2i] & ~b[2i-1]), and neg n = b[2i+1].
  - mag = s ? sext(a) : d ? sext(a)<<1 : 0, computed at 2*WIDTH bits.
  - pp = (n ? ~mag : mag) + n.
  - acc += pp << 2i, modulo 2^(2*WIDTH).
  - Triplet 111 gives n=1 with mag=0. This must yield pp=0 (~0+1 wraps to 0). Do not special-case it.
  - After the edge that performs iteration N-1, the state moves to DONE.
- Latency:
  - The accept edge is edge 0; iterations occur on edges 1..N.
  - out_valid rises after edge N.
  - For WIDTH=16, out_valid rises 8 cycles after the accept edge.
- DONE:
  - out_valid=1 and product=acc; both are held stable while out_ready=0.
  - in_ready = out_ready, so a new pair can be accepted in the same cycle the product is taken.
  - out_ready=1 with in_valid=1: the result is consumed, the new pair is latched, and the state moves to RUN. There is no bubble.
  - out_ready=1 with in_valid=0: the state moves to IDLE and out_valid drops on the next edge.
- Boundary conditions:
  - in_valid while in RUN is ignored; in_ready=0 and no operand is sampled.
  - a, b may change freely after acceptance.
  - rst_n=0 mid-RUN or in DONE aborts the operation. The pending product is discarded and all outputs return to reset values on that edge.
  - -2^(WIDTH-1) * -2^(WIDTH-1) = 2^(2*WIDTH-2) is exact in 2*WIDTH bits; no overflow is possible.
- product is registered. It is held through IDLE and RUN until the next DONE and is qualified only by out_valid.

Optional Feature:
- Macro: BOOTH_UNSIGNED_MODE_EN.
- Defined:
  - Adds input port sgn (1 bit), sampled at accept.
  - sgn=0 treats a and b as unsigned: a and b are zero-extended, and N=WIDTH/2+1 iterations run, with the extra triplet {0, 0, b[WIDTH-1]}.
  - Latency becomes N=WIDTH/2+1 in both modes (fixed, for scheduling simplicity).
  - sgn=1 behaves as signed; the extra iteration encodes {b[WIDTH-1] x3}, which gives pp=0.
- Undefined:
  - No sgn port; signed only; N=WIDTH/2.

Decomposition:
- Shared package booth_pkg:
  - state enum {IDLE, RUN, DONE}.
  - localparam for N derived from WIDTH.
  - typedef for the encoder select struct {s, d, n}.
- Sub-module booth_pp_gen (combinational):
  - Inputs: triplet[2:0], multiplicand[WIDTH-1:0].
  - Output: pp[2*WIDTH-1:0], unshifted.
  - Instantiated once; the controller owns the counter, shift and accumulator.

Test Plan:
- Basic signed multiply (WIDTH=8): a=7, b=3, out_ready=1 -> product=16'd21. out_valid asserts exactly 4 cycles after the accept edge and lasts 1 cycle.
- Negative and all-ones multiplier: a=5, b=8'hFF (-1) -> 16'hFFFB. Then a=-128, b=-128 -> 16'h4000. Then a=8'h7F, b=8'h80 -> 16'hC080.
- Backpressure and ignored input: out_ready=0 for 10 cycles after out_valid -> product held stable and in_ready=0; in_valid pulsed during RUN is not sampled.
- Back-to-back: in_valid held high with pairs (3,4), (-2,6), (0,-5) and out_ready=1 -> products 12, 16'hFFF4, 0 on consecutive 4-cycle boundaries with no idle cycle.
- Reset mid-operation: rst_n=0 for one edge at iteration 2 -> out_valid=0, product=0, busy=0, in_ready=1 next cycle. A subsequent a=2, b=2 -> product 4.
- Unsigned mode (BOOTH_UNSIGNED_MODE_EN, sgn=0, WIDTH=8): a=8'hFF, b=8'hFF -> 16'hFE01 after 5 cycles. Same operands with sgn=1 -> 16'h0001.
